// File: rtl/restoring_divider.sv
// Unsigned 8-bit restoring divider: one SHIFT/SUB pair per quotient bit, divisor
// held in its own register loaded through a dedicated LOADD state.
module restoring_divider (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Load_D,
  input  logic [7:0] Din,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       Div_Zero,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOADD, S_INIT, S_SHIFT, S_SUB, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] quo_q, quo_d;
  logic [7:0] rem_q, rem_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dz_q, dz_d;
  logic [8:0] diff;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    diff    = {1'b0, rem_q} - {1'b0, div_q};
    case (state_q)
      S_IDLE: begin
        if (Load_D)   state_d = S_LOADD;
        else if (Run) state_d = S_INIT;
      end
      S_LOADD: begin
        div_d   = Din;
        state_d = S_IDLE;
      end
      S_INIT: begin
        cnt_d = '0;
        dz_d  = (div_q == 8'd0);
        if (div_q == 8'd0) begin
          // Divide-by-zero: saturate quotient, hand the dividend back as remainder
          quo_d   = 8'hFF;
          rem_d   = Din;
          state_d = S_DONE;
        end else begin
          quo_d   = Din;
          rem_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Remainder entering a shift is always < 128, so no bit is lost off the top
        {rem_d, quo_d} = {rem_q[6:0], quo_q, 1'b0};
        state_d        = S_SUB;
      end
      S_SUB: begin
        if (!diff[8]) begin
          rem_d    = diff[7:0];
          quo_d[0] = 1'b1;
        end else begin
          quo_d[0] = 1'b0;
        end
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (!Run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign Div_Zero  = dz_q;
  assign Busy      = (state_q == S_INIT) || (state_q == S_SHIFT) || (state_q == S_SUB);
  assign Done      = (state_q == S_DONE);

endmodule
